// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state, tap count and window ordering for the 3x3 window front end
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } conv_state_t;

    localparam int WIN_TAPS = 9;
    localparam int WIN_DIM  = 3;

    // Lane of a tap in the flattened window; offsets count back from the newest pixel,
    // so (0,0) is the LSB lane and (2,2), the oldest pixel, is the MSB lane.
    function automatic int tap_slot(input int row_back, input int col_back);
        return row_back * WIN_DIM + col_back;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// rtl/conv_window_ctrl_if.sv - pixel-in and window-out handshakes of the window sequencer
interface conv_window_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4
);
    import conv_pkg::*;

    localparam int ROW_W = idx_width(IMG_HEIGHT);
    localparam int COL_W = idx_width(IMG_WIDTH);

    logic                           in_valid;
    logic signed [DATA_WIDTH-1:0]   in_data;
    logic                           in_ready;
    logic                           win_valid;
    logic                           win_ready;
    logic [WIN_TAPS*DATA_WIDTH-1:0] win_data;
    logic [ROW_W-1:0]               win_row;
    logic [COL_W-1:0]               win_col;

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, win_row, win_col
    );

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, win_row, win_col
    );

endinterface

// File: rtl/line_buffer_en.sv
// rtl/line_buffer_en.sv - 3x3 line buffer: two row delays feeding three 3-tap shifters, all gated by shift_en
module line_buffer_en
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           shift_en,
    input  logic [DATA_WIDTH-1:0]          pixel,
    output logic [WIN_TAPS*DATA_WIDTH-1:0] window
);

    logic [DATA_WIDTH-1:0] row_dly1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] row_dly2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] taps     [WIN_DIM][WIN_DIM];
    logic [DATA_WIDTH-1:0] row_in   [WIN_DIM];

    // Each shifter is fed with the pixel that entered 0, W or 2W shifts ago.
    always_comb begin
        row_in[0] = pixel;
        row_in[1] = row_dly1[IMG_WIDTH-1];
        row_in[2] = row_dly2[IMG_WIDTH-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                row_dly1[i] <= '0;
                row_dly2[i] <= '0;
            end
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    taps[r][c] <= '0;
                end
            end
        end else if (shift_en) begin
            row_dly1[0] <= pixel;
            row_dly2[0] <= row_dly1[IMG_WIDTH-1];
            for (int i = 1; i < IMG_WIDTH; i++) begin
                row_dly1[i] <= row_dly1[i-1];
                row_dly2[i] <= row_dly2[i-1];
            end
            for (int r = 0; r < WIN_DIM; r++) begin
                taps[r][0] <= row_in[r];
                for (int c = 1; c < WIN_DIM; c++) begin
                    taps[r][c] <= taps[r][c-1];
                end
            end
        end
    end

    for (genvar r = 0; r < WIN_DIM; r++) begin : g_row
        for (genvar c = 0; c < WIN_DIM; c++) begin : g_col
            assign window[tap_slot(r, c)*DATA_WIDTH +: DATA_WIDTH] = taps[r][c];
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - raster pixel sequencer presenting legal 3x3 windows with backpressure
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    conv_window_ctrl_if.slave   bus,
    output logic                busy,
    output logic                done
);

    localparam int ROW_W = idx_width(IMG_HEIGHT);
    localparam int COL_W = idx_width(IMG_WIDTH);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);

    conv_state_t                    state;
    logic [ROW_W-1:0]               row;
    logic [COL_W-1:0]               col;
    logic                           win_valid_q;
    logic [ROW_W-1:0]               win_row_q;
    logic [COL_W-1:0]               win_col_q;
    logic [WIN_TAPS*DATA_WIDTH-1:0] window;
    logic                           in_ready_c;
    logic                           fire;
    logic                           consume;
    logic                           qualifies;
    logic                           last_pixel;

    // A pending window blocks the next shift so its taps stay frozen until taken.
    assign in_ready_c = (state == STREAM) && (!win_valid_q || bus.win_ready);
    assign fire       = bus.in_valid && in_ready_c;
    assign consume    = win_valid_q && bus.win_ready;
    assign qualifies  = (row >= ROW_MIN) && (col >= COL_MIN);
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

    assign bus.in_ready  = in_ready_c;
    assign bus.win_valid = win_valid_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.win_data  = window;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_pixel) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!win_valid_q || bus.win_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Qualification uses the position before this fire's increment.
            if (fire) begin
                win_valid_q <= qualifies;
                if (qualifies) begin
                    win_row_q <= row;
                    win_col_q <= col;
                end
            end else if (consume) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    line_buffer_en #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH)
    ) u_line_buffer (
        .clk      (clk),
        .reset    (reset),
        .shift_en (fire),
        .pixel    (bus.in_data),
        .window   (window)
    );

endmodule
